// File: rtl/button_matrix_scanner.sv
// button_matrix_scanner
//
// Scans a ROWS x COLS button matrix. One row is driven at a time. After a dwell of SCAN_DIV cycles,
// the synchronised columns are captured. Each key of that row is then evaluated, one column per
// cycle, against its own debounce counter. Debounced presses and releases are queued as events in
// a small FIFO that the consumer drains over a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   row_drive  one-hot active-high row drive
//   col_sense  raw column inputs (high = pressed on driven row), asynchronous to clk
//   key_state  debounced key state, bit row*COLS+col
//   evt_valid  FIFO non-empty
//   evt_ready  consumer accepts head event
//   evt_index  head event key index
//   evt_press  head event type: 1 press, 0 release
//   evt_drop   one-cycle pulse when an event is discarded because the FIFO is full
module button_matrix_scanner #(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned SCAN_DIV       = 1200,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned IDX_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ROWS-1:0]        row_drive,
    input  logic [COLS-1:0]        col_sense,
    output logic [ROWS*COLS-1:0]   key_state,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [IDX_W-1:0]       evt_index,
    output logic                   evt_press,
    output logic                   evt_drop
);

    localparam int unsigned KEYS  = ROWS * COLS;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DW    = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // Column synchroniser
    // ------------------------------------------------------------------
    logic [COLS-1:0] col_meta_q, col_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
        end else begin
            col_meta_q <= col_sense;
            col_sync_q <= col_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {StSettle, StEval} scan_state_e;

    scan_state_e     state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] sample_q, sample_d;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        dwell_d  = dwell_q;
        col_d    = col_q;
        sample_d = sample_q;
        unique case (state_q)
            StSettle: begin
                if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    sample_d = col_sync_q;
                    col_d    = '0;
                    state_d  = StEval;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StEval: begin
                if (col_q == CW'(COLS - 1)) begin
                    col_d   = '0;
                    dwell_d = '0;
                    row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                    state_d = StSettle;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = StSettle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StSettle;
            row_q    <= '0;
            dwell_q  <= '0;
            col_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            dwell_q  <= dwell_d;
            col_q    <= col_d;
            sample_q <= sample_d;
        end
    end

    assign row_drive = ROWS'(1) << row_q;

    // ------------------------------------------------------------------
    // Per-key debounce
    // ------------------------------------------------------------------
    logic             eval_en;
    logic [IDX_W-1:0] key_idx;
    logic             sample_bit;
    logic             push;
    logic [CNT_W-1:0] cnt_q [KEYS];
    logic [CNT_W-1:0] cnt_d [KEYS];
    logic [KEYS-1:0]  key_state_q, key_state_d;

    assign eval_en    = (state_q == StEval);
    assign key_idx    = IDX_W'(32'(row_q) * COLS + 32'(col_q));
    assign sample_bit = sample_q[col_q];

    always_comb begin
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        push        = 1'b0;
        if (eval_en) begin
            if (sample_bit == key_state_q[key_idx]) begin
                cnt_d[key_idx] = '0;
            end else if (32'(cnt_q[key_idx]) + 32'd1 >= DEBOUNCE_SCANS) begin
                // Enough consecutive disagreeing samples: commit the new level.
                cnt_d[key_idx]       = '0;
                key_state_d[key_idx] = sample_bit;
                push                 = 1'b1;
            end else begin
                cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_q <= '0;
            for (int i = 0; i < int'(KEYS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign key_state = key_state_q;

    // ------------------------------------------------------------------
    // Event FIFO, entries are {index, press}
    // ------------------------------------------------------------------
    logic [IDX_W:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCW-1:0] count_q;
    logic           full, pop, push_ok;

    assign full      = (count_q == FCW'(FIFO_DEPTH));
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok   = push && (!full || pop);
    assign evt_drop  = push && full && !pop;

    assign {evt_index, evt_press} = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr_q] <= {key_idx, sample_bit};
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_matrix_scanner.sv
module tb_button_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 8;
    localparam int DS       = 4;
    localparam int DEPTH    = 4;
    localparam int KEYS     = ROWS * COLS;
    localparam int IDX_W    = 4;
    localparam int P        = SCAN_DIV + COLS;
    localparam int FRAME    = ROWS * P;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ROWS-1:0]   row_drive;
    logic [COLS-1:0]   col_sense;
    logic [KEYS-1:0]   key_state;
    logic              evt_valid;
    logic              evt_ready = 1'b1;
    logic [IDX_W-1:0]  evt_index;
    logic              evt_press;
    logic              evt_drop;

    logic [KEYS-1:0]   pressed = '0;

    int tests = 0;
    int fails = 0;

    button_matrix_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_drive(row_drive),
        .col_sense(col_sense),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_index(evt_index),
        .evt_press(evt_press),
        .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key connects the driven row to its column.
    always_comb begin
        col_sense = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_drive[r]) col_sense = col_sense | pressed[r*COLS +: COLS];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: cycle n after reset belongs to row (n/P)%ROWS;
    // its last COLS cycles evaluate one key each.
    // ------------------------------------------------------------------
    int          m_n = 0;
    bit [KEYS-1:0] m_state = '0;
    int          m_cnt [KEYS];
    int unsigned m_q [$];
    int          drop_pulses = 0;
    int          valid_cycles = 0;

    always @(negedge clk) begin : model
        int row, p, c, k;
        bit push, smp, pop, drop, flip;
        if (rst) begin
            check("rst_row_drive", row_drive, 1);
            check("rst_key_state", key_state, 0);
            check("rst_evt_valid", evt_valid, 0);
            check("rst_evt_index", evt_index, 0);
            check("rst_evt_press", evt_press, 0);
            check("rst_evt_drop", evt_drop, 0);
            m_n = 0;
            m_state = '0;
            for (int i = 0; i < KEYS; i++) m_cnt[i] = 0;
            m_q.delete();
        end else begin
            row = (m_n / P) % ROWS;
            p = m_n % P;
            push = 1'b0;
            flip = 1'b0;
            smp = 1'b0;
            k = 0;
            c = 0;
            if (p >= SCAN_DIV) begin
                c = p - SCAN_DIV;
                k = row * COLS + c;
                smp = pressed[k];
                if (smp != m_state[k] && m_cnt[k] + 1 == DS) begin
                    push = 1'b1;
                    flip = 1'b1;
                end
            end
            pop = (m_q.size() > 0) && evt_ready;
            drop = push && (m_q.size() == DEPTH) && !pop;

            check("row_drive", row_drive, 1 << row);
            check("key_state", key_state, m_state);
            check("evt_valid", evt_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                check("evt_index", evt_index, m_q[0] >> 1);
                check("evt_press", evt_press, m_q[0] & 1);
            end
            check("evt_drop", evt_drop, drop);
            if (evt_drop) drop_pulses++;
            if (evt_valid) valid_cycles++;

            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(unsigned'(k * 2 + int'(smp)));
            if (p >= SCAN_DIV) begin
                if (smp == m_state[k]) m_cnt[k] = 0;
                else if (flip) begin
                    m_cnt[k] = 0;
                    m_state[k] = smp;
                end else m_cnt[k]++;
            end
            m_n++;
        end
    end

    // At posedge+#1 of cycle n, m_n == n.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic goto_frame_start();
        while (m_n % FRAME != 0) tick();
    endtask

    initial begin
        ticks(3);
        rst = 1'b0;

        // Idle scan: row_drive walks one-hot, one row per P cycles.
        ticks(P);
        check("idle_row1", row_drive, 4'b0010);
        ticks(P);
        check("idle_row2", row_drive, 4'b0100);
        ticks(P);
        check("idle_row3", row_drive, 4'b1000);
        ticks(P);
        check("idle_row0", row_drive, 4'b0001);
        ticks(2 * FRAME);
        check("idle_valid", evt_valid, 0);

        // Key (1,2) press: key 6 evaluated at cycle P+SCAN_DIV+2 = 22 of each frame.
        goto_frame_start();
        pressed[6] = 1'b1;
        ticks(3 * FRAME + 22);
        check("press6_before", evt_valid, 0);
        tick();
        check("press6_valid", evt_valid, 1);
        check("press6_index", evt_index, 6);
        check("press6_type", evt_press, 1);
        check("press6_state", key_state[6], 1);
        goto_frame_start();
        pressed[6] = 1'b0;
        ticks(3 * FRAME + 23);
        check("rel6_valid", evt_valid, 1);
        check("rel6_index", evt_index, 6);
        check("rel6_type", evt_press, 0);
        check("rel6_state", key_state[6], 0);

        // Key (3,0) bounce: 3 frames high, 1 low, twice.
        goto_frame_start();
        drop_pulses = 0;
        valid_cycles = 0;
        for (int rep = 0; rep < 2; rep++) begin
            pressed[12] = 1'b1;
            ticks(3 * FRAME);
            pressed[12] = 1'b0;
            ticks(FRAME);
        end
        check("bounce_state", key_state, 0);
        check("bounce_drops", drop_pulses, 0);
        check("bounce_events", valid_cycles, 0);

        // Keys 9 and 11 in the same frame, held until row 2 EVAL has finished.
        goto_frame_start();
        evt_ready = 1'b0;
        pressed[9] = 1'b1;
        pressed[11] = 1'b1;
        ticks(3 * FRAME + 36);
        check("pair_first_valid", evt_valid, 1);
        check("pair_first_index", evt_index, 9);
        evt_ready = 1'b1;
        tick();
        check("pair_second_index", evt_index, 11);
        check("pair_second_type", evt_press, 1);
        tick();
        check("pair_drained", evt_valid, 0);
        goto_frame_start();
        pressed = '0;
        ticks(5 * FRAME);

        // Five presses into a 4-deep FIFO: key 4 (cycle 20) is dropped.
        goto_frame_start();
        evt_ready = 1'b0;
        pressed[4:0] = 5'h1f;
        ticks(3 * FRAME + 20);
        check("full_drop", evt_drop, 1);
        check("full_head", evt_index, 0);
        tick();
        check("full_drop_end", evt_drop, 0);
        check("full_state", key_state, 16'h001f);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", evt_valid, 1);
            check("drain_index", evt_index, i);
            check("drain_type", evt_press, 1);
            tick();
        end
        check("drain_empty", evt_valid, 0);

        // Releases refill the FIFO; key 4's release lands while the head is popped.
        goto_frame_start();
        evt_ready = 1'b0;
        pressed = '0;
        ticks(3 * FRAME + 20);
        check("concur_head", evt_index, 0);
        check("concur_head_type", evt_press, 0);
        evt_ready = 1'b1;
        #1;
        check("concur_no_drop", evt_drop, 0);
        tick();
        evt_ready = 1'b0;
        check("concur_state", key_state, 0);
        evt_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("concur_index", evt_index, i);
            check("concur_type", evt_press, 0);
            tick();
        end
        check("concur_empty", evt_valid, 0);

        // Reset during EVAL of row 2 with two events queued.
        goto_frame_start();
        evt_ready = 1'b0;
        pressed[1:0] = 2'b11;
        ticks(3 * FRAME + 32);
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_state", key_state, 16'h0003);
        check("pre_rst_row", row_drive, 4'b0100);
        rst = 1'b1;
        tick();
        check("post_rst_valid", evt_valid, 0);
        check("post_rst_state", key_state, 0);
        check("post_rst_row", row_drive, 4'b0001);
        pressed = '0;
        tick();
        rst = 1'b0;
        evt_ready = 1'b1;
        ticks(FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_matrix_scanner.md
# button_matrix_scanner

Parametrised ROWS×COLS button-matrix scanner for the sequencer front panel. It drives matrix rows one-hot, samples synchronised column inputs and debounces every key independently. Each debounced press or release becomes an event in a small FIFO, read by the sequencer model over a valid/ready handshake. Unlike the single-OR-debounce front end, it resolves simultaneous keys and reports both edges per key.

## Interface
Parameters:
- ROWS, 4, matrix rows (≥1)
- COLS, 4, matrix columns (≥1)
- SCAN_DIV, 1200, row dwell in clk cycles before sampling (≥3, covers the 2-FF synchroniser)
- DEBOUNCE_SCANS, 4, consecutive disagreeing samples of a key needed to flip its state (≥1)
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2)

Ports (IDX_W = $clog2(ROWS*COLS), min 1):
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- row_drive  out  ROWS  one-hot active-high row drive
- col_sense  in  COLS  raw column inputs, high = pressed on the driven row; asynchronous to clk
- key_state  out  ROWS*COLS  debounced state; bit row*COLS+col
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_index  out  IDX_W  head event key index = row*COLS+col
- evt_press  out  1  head event type: 1 press, 0 release
- evt_drop  out  1  one-cycle pulse: event discarded, FIFO full

## Operation
- col_sense passes through a 2-FF synchroniser before any use.
- Scan FSM, two states, row counter r in 0..ROWS-1:
  - SETTLE: row_drive = one-hot(r). Dwell counter counts 0..SCAN_DIV-1. On the last cycle, capture the synchronised columns into sample[COLS-1:0], then go to EVAL with c=0.
  - EVAL: one cycle per column, c = 0..COLS-1. Evaluate key k = r*COLS+c. After c = COLS-1, r wraps modulo ROWS, the dwell counter clears and the FSM returns to SETTLE. row_drive holds one-hot(r) through EVAL.
- Per-key debounce:
  - Each key has a counter, width $clog2(DEBOUNCE_SCANS+1).
  - In EVAL, if sample[c] equals key_state[k], the counter clears.
  - Otherwise the counter increments. When it would reach DEBOUNCE_SCANS, key_state[k] flips to sample[c], the counter clears and an event {k, sample[c]} is pushed.
- Push rules:
  - A push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise evt_drop pulses for that cycle and the event is lost.
  - key_state still flips when an event is dropped.
- Pop occurs when evt_valid && evt_ready. evt_index and evt_press always reflect the head entry and are stable while evt_valid=1 and evt_ready=0.
- Events leave in push order: row-major scan order; within one row, ascending column.

## Timing
- Reset values: row_drive = one-hot(0); key_state = 0; all debounce counters = 0; FIFO empty; evt_valid = 0; evt_index = 0; evt_press = 0; evt_drop = 0; FSM in SETTLE with r=0 and dwell=0; synchroniser flops = 0.
- Asserting rst mid-scan or mid-EVAL returns to the full reset state immediately. Pending FIFO events are discarded.
- Row period is SCAN_DIV+COLS cycles. Full-frame period is ROWS*(SCAN_DIV+COLS) cycles. The same key is evaluated exactly once per frame.
- Event latency: evt_valid rises the cycle after the EVAL cycle that pushes into an empty FIFO.
- Debounce latency: a clean level change is reported on the DEBOUNCE_SCANS-th EVAL of that key after the first sample showing the new level.
- Any glitch or bounce shorter than DEBOUNCE_SCANS consecutive frames produces no event.
- The column sample is taken 2 synchroniser cycles before the end of dwell at the earliest. Settling therefore gets SCAN_DIV-2 cycles.

## Test plan
- Reset, then no stimulus for 3 frames: row_drive cycles 0001→0010→0100→1000→0001 with SCAN_DIV+COLS cycles per row. evt_valid stays 0.
- Key (1,2) held high, DEBOUNCE_SCANS=4, evt_ready=1: exactly one event, index 6, press=1, on the 4th EVAL of key 6; key_state[6]=1. Release the key: one event, index 6, press=0, 4 frames later.
- Key (3,0) bounces: high for 3 frames, low for 1, repeated. No event and no drop are produced; key_state[12] stays 0.
- Keys (2,1) and (2,3) pressed in the same frame: events index 9 then index 11, on consecutive cycles after EVAL of row 2.
- evt_ready=0 with FIFO_DEPTH=4 and 5 distinct key presses: 4 events are retained in order. The 5th press gives a one-cycle evt_drop, and key_state still shows all 5 keys. Raising evt_ready drains the 4 events in order. Pop concurrent with push on a full FIFO drops nothing.
- rst asserted during EVAL of row 2 while 2 events are queued: next cycle evt_valid=0, key_state=0 and row_drive=0001.
